// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if: speed command handshake into the ramp sequencer.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer can accept a command
//   cmd_speed  master->slave  target speed code
//   cmd_dwell  master->slave  clocks per step minus one
interface pwm_ramp_sequencer_if #(
    parameter int unsigned SPEED_W = 3,
    parameter int unsigned DWELL_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [SPEED_W-1:0] cmd_speed;
    logic [DWELL_W-1:0] cmd_dwell;

    modport master (
        output cmd_valid,
        output cmd_speed,
        output cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_speed,
        input  cmd_dwell,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: soft-start/soft-stop controller for the ancho PWM core.
// Steps the speed code one unit at a time toward a commanded target, holding
// each level for dwell+1 clocks, so the PWM duty never jumps by more than one code.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   cmd         command handshake (slave modport): valid/ready/speed/dwell
//   stop_req    abort request, only present with PWM_RAMP_ABORT_EN defined
//   pwm_enable  to PWM core enable
//   pwm_speed   to PWM core speed
//   busy        ramp in progress
//   done        one-cycle pulse when the target is reached
//
// Build option: define PWM_RAMP_ABORT_EN to add stop_req, which forces a ramp
// down to zero from RAMP_UP, RAMP_DOWN or HOLD.
module pwm_ramp_sequencer #(
    parameter int unsigned SPEED_W = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    pwm_ramp_sequencer_if.slave cmd,
`ifdef PWM_RAMP_ABORT_EN
    input  logic               stop_req,
`endif
    output logic               pwm_enable,
    output logic [SPEED_W-1:0] pwm_speed,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown, StHold} state_e;

    state_e             state;
    logic [SPEED_W-1:0] target;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] cnt;
    logic [SPEED_W-1:0] speed_up;
    logic [SPEED_W-1:0] speed_dn;
    logic [SPEED_W-1:0] dn_target;
    logic               stop;
    logic               accept;

`ifdef PWM_RAMP_ABORT_EN
    assign stop = stop_req;
`else
    assign stop = 1'b0;
`endif

    assign speed_up = pwm_speed + 1'b1;
    assign speed_dn = pwm_speed - 1'b1;
    // A stop held during RAMP_DOWN retargets to zero on the same edge.
    assign dn_target = stop ? '0 : target;

    assign cmd.cmd_ready = ((state == StIdle) || (state == StHold)) && !stop;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state == StRampUp) || (state == StRampDown);
    assign pwm_enable    = (state != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            pwm_speed <= '0;
            target    <= '0;
            dwell     <= '0;
            cnt       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && (state == StRampUp || state == StHold)) begin
                // Reverse without touching the counter so the current step continues.
                target <= '0;
                if (pwm_speed == '0) begin
                    state <= StIdle;
                    cnt   <= '0;
                    done  <= 1'b1;
                end else begin
                    state <= StRampDown;
                end
            end else begin
                case (state)
                    StIdle, StHold: begin
                        if (accept) begin
                            target <= cmd.cmd_speed;
                            dwell  <= cmd.cmd_dwell;
                            cnt    <= '0;
                            if (cmd.cmd_speed > pwm_speed) begin
                                state <= StRampUp;
                            end else if (cmd.cmd_speed < pwm_speed) begin
                                state <= StRampDown;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    StRampUp: begin
                        if (cnt == dwell) begin
                            cnt       <= '0;
                            pwm_speed <= speed_up;
                            if (speed_up == target) begin
                                state <= StHold;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StRampDown: begin
                        if (stop) begin
                            target <= '0;
                        end
                        if (cnt == dwell) begin
                            cnt       <= '0;
                            pwm_speed <= speed_dn;
                            if (speed_dn == dn_target) begin
                                state <= (dn_target == '0) ? StIdle : StHold;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: directed self-checking bench for pwm_ramp_sequencer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pwm_ramp_sequencer;

    logic       clock;
    logic       reset;
    logic       pwm_enable;
    logic [2:0] pwm_speed;
    logic       busy;
    logic       done;
`ifdef PWM_RAMP_ABORT_EN
    logic       stop_req;
`endif

    int n_tests;
    int n_fail;

    pwm_ramp_sequencer_if #(.SPEED_W(3), .DWELL_W(8)) cmd_if ();

    pwm_ramp_sequencer #(.SPEED_W(3), .DWELL_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd_if),
`ifdef PWM_RAMP_ABORT_EN
        .stop_req   (stop_req),
`endif
        .pwm_enable (pwm_enable),
        .pwm_speed  (pwm_speed),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] spd, input logic [7:0] dw);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_speed = spd;
        cmd_if.cmd_dwell = dw;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_speed = 3'd5;
        cmd_if.cmd_dwell = 8'd0;
        tick();
        tick();
        n_tests++;
        if (pwm_speed !== 3'd0 || pwm_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: spd=%0d en=%b busy=%b done=%b rdy=%b want 0 0 0 0 1",
                     pwm_speed, pwm_enable, busy, done, cmd_if.cmd_ready);
        end
        reset = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        tick();
        n_tests++;
        if (pwm_enable !== 1'b0 || pwm_speed !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_cmd: en=%b spd=%0d busy=%b want 0 0 0",
                     pwm_enable, pwm_speed, busy);
        end
    endtask

    task automatic test_ramp_up();
        logic [2:0] exp_s;
        send(3'd5, 8'd2);
        n_tests++;
        if (pwm_enable !== 1'b1 || busy !== 1'b1 || pwm_speed !== 3'd0
            || cmd_if.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL up_accept: en=%b busy=%b spd=%0d rdy=%b want 1 1 0 0",
                     pwm_enable, busy, pwm_speed, cmd_if.cmd_ready);
        end
        for (int t = 1; t <= 15; t++) begin
            tick();
            exp_s = 3'(t / 3);
            n_tests++;
            if (pwm_speed !== exp_s || done !== (t == 15) || busy !== (t != 15)) begin
                n_fail++;
                $display("FAIL up_step t=%0d: spd=%0d done=%b busy=%b want %0d %b %b",
                         t, pwm_speed, done, busy, exp_s, (t == 15), (t != 15));
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || pwm_speed !== 3'd5
            || pwm_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL up_hold: done=%b rdy=%b spd=%0d en=%b want 0 1 5 1",
                     done, cmd_if.cmd_ready, pwm_speed, pwm_enable);
        end
    endtask

    task automatic test_ramp_down_hold();
        logic [2:0] exp_s;
        int         pulses;
        pulses = 0;
        send(3'd2, 8'd0);
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (done === 1'b1) pulses++;
            exp_s = (t < 3) ? 3'(5 - t) : 3'd2;
            n_tests++;
            if (pwm_speed !== exp_s || pwm_enable !== 1'b1) begin
                n_fail++;
                $display("FAIL down_step t=%0d: spd=%0d en=%b want %0d 1",
                         t, pwm_speed, pwm_enable, exp_s);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL down_done_count: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_ramp_to_zero();
        logic [2:0] exp_s;
        send(3'd0, 8'd1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            exp_s = 3'(2 - t / 2);
            n_tests++;
            if (pwm_speed !== exp_s || pwm_enable !== (t < 4) || done !== (t == 4)) begin
                n_fail++;
                $display("FAIL zero_step t=%0d: spd=%0d en=%b done=%b want %0d %b %b",
                         t, pwm_speed, pwm_enable, done, exp_s, (t < 4), (t == 4));
            end
        end
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: rdy=%b busy=%b want 1 0", cmd_if.cmd_ready, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || pwm_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b en=%b want 0 0", done, pwm_enable);
        end
    endtask

    task automatic test_busy_ignore();
        logic [2:0] exp_s;
        send(3'd7, 8'd1);
        for (int t = 1; t <= 14; t++) begin
            cmd_if.cmd_valid = (t >= 3 && t <= 10);
            cmd_if.cmd_speed = 3'd1;
            cmd_if.cmd_dwell = 8'd0;
            tick();
            exp_s = 3'(t / 2);
            n_tests++;
            if (pwm_speed !== exp_s || cmd_if.cmd_ready !== (t == 14)) begin
                n_fail++;
                $display("FAIL busy_ignore t=%0d: spd=%0d rdy=%b want %0d %b",
                         t, pwm_speed, cmd_if.cmd_ready, exp_s, (t == 14));
            end
        end
        cmd_if.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if (pwm_speed !== 3'd7 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_final: spd=%0d busy=%b want 7 0", pwm_speed, busy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send(3'd7, 8'd1);
        for (int t = 1; t <= 5; t++) tick();
        n_tests++;
        if (pwm_speed !== 3'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: spd=%0d busy=%b want 2 1", pwm_speed, busy);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (pwm_speed !== 3'd0 || pwm_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: spd=%0d en=%b busy=%b done=%b rdy=%b want 0 0 0 0 1",
                     pwm_speed, pwm_enable, busy, done, cmd_if.cmd_ready);
        end
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if (pwm_speed !== 3'd0 || pwm_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: spd=%0d en=%b want 0 0", pwm_speed, pwm_enable);
        end
    endtask

    task automatic test_equal_target();
        send(3'd0, 8'd5);
        n_tests++;
        if (done !== 1'b1 || pwm_enable !== 1'b0 || busy !== 1'b0
            || cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL equal_accept: done=%b en=%b busy=%b rdy=%b want 1 0 0 1",
                     done, pwm_enable, busy, cmd_if.cmd_ready);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || pwm_enable !== 1'b0 || pwm_speed !== 3'd0) begin
            n_fail++;
            $display("FAIL equal_after: done=%b en=%b spd=%0d want 0 0 0",
                     done, pwm_enable, pwm_speed);
        end
    endtask

`ifdef PWM_RAMP_ABORT_EN
    task automatic test_abort();
        logic [2:0] exp_s;
        send(3'd6, 8'd3);
        for (int t = 1; t <= 12; t++) tick();
        n_tests++;
        if (pwm_speed !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_pre: spd=%0d want 3", pwm_speed);
        end
        stop_req = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            tick();
            exp_s = 3'(3 - (t - 1) / 4);
            n_tests++;
            if (pwm_speed !== exp_s || done !== (t == 13) || pwm_enable !== (t < 13)
                || cmd_if.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_step t=%0d: spd=%0d done=%b en=%b rdy=%b want %0d %b %b 0",
                         t, pwm_speed, done, pwm_enable, cmd_if.cmd_ready,
                         exp_s, (t == 13), (t < 13));
            end
        end
        tick();
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b0 || done !== 1'b0 || pwm_speed !== 3'd0
            || pwm_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: rdy=%b done=%b spd=%0d en=%b want 0 0 0 0",
                     cmd_if.cmd_ready, done, pwm_speed, pwm_enable);
        end
        stop_req = 1'b0;
        #1;
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release: rdy=%b want 1", cmd_if.cmd_ready);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_speed = 3'd0;
        cmd_if.cmd_dwell = 8'd0;
`ifdef PWM_RAMP_ABORT_EN
        stop_req = 1'b0;
`endif
        test_reset();
        test_ramp_up();
        test_ramp_down_hold();
        test_ramp_to_zero();
        test_busy_ignore();
        test_reset_mid_ramp();
        test_equal_target();
`ifdef PWM_RAMP_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Soft-start/soft-stop controller for the `ancho` PWM core.
- Accepts speed commands over a valid/ready handshake.
- Steps the 3-bit speed code one unit at a time toward the commanded target, holding each level for a programmable dwell time.
- Drives the PWM core's enable and speed inputs, so the duty never jumps more than one code per step.

Parameters:
- SPEED_W, 3, width of speed code; matches the PWM core speed input.
- DWELL_W, 8, width of the dwell field; a dwell value D holds each step for D+1 clocks.

Ports:
- clock      input   1        system clock; all logic on rising edge
- reset      input   1        synchronous, active-high reset
- cmd_valid  input   1        command present
- cmd_ready  output  1        sequencer can accept a command
- cmd_speed  input   SPEED_W  target speed code
- cmd_dwell  input   DWELL_W  clocks per step minus one
- pwm_enable output  1        to PWM core enable
- pwm_speed  output  SPEED_W  to PWM core speed
- busy       output  1        ramp in progress
- done       output  1        one-cycle pulse when target is reached

Behaviour:
- Reset (sampled on the clock edge while reset=1):
  - state=IDLE; pwm_speed=0; pwm_enable=0; cmd_ready=1; busy=0; done=0; dwell counter=0; latched target/dwell=0.
  - Reset overrides every other input, including a simultaneous cmd_valid; that command is dropped.
- States: IDLE, RAMP_UP, RAMP_DOWN, HOLD. All outputs are registered or decoded from registered state only.
- cmd_ready:
  - =1 in IDLE and HOLD, =0 in RAMP_UP and RAMP_DOWN.
  - Accept = cmd_valid & cmd_ready on a clock edge. On accept, latch cmd_speed as target and cmd_dwell as dwell, and clear the dwell counter.
  - Commands presented while cmd_ready=0 are ignored (not queued); the requester must hold cmd_valid.
- Transition on accept edge:
  - target > pwm_speed -> RAMP_UP.
  - target < pwm_speed -> RAMP_DOWN.
  - target == pwm_speed -> no state change (stay IDLE or HOLD); done=1 for the next cycle.
- In RAMP states, each edge:
  - If counter==dwell: counter<=0 and pwm_speed<=pwm_speed±1.
  - Otherwise: counter<=counter+1.
  - First step therefore occurs dwell+1 edges after the accept edge; consecutive steps are dwell+1 edges apart.
- Arrival: on the edge where the stepped value equals target:
  - Go to HOLD if target≠0, or to IDLE if target==0.
  - done=1 during the following cycle only.
  - pwm_speed never passes target; no wrap-around at 0 or 2^SPEED_W-1.
- busy = (state==RAMP_UP | state==RAMP_DOWN).
- pwm_enable:
  - =1 in RAMP_UP, RAMP_DOWN and HOLD; =0 in IDLE.
  - It rises on the accept edge that enters RAMP_UP. It falls on the same edge on which pwm_speed reaches 0 at the end of RAMP_DOWN.
- HOLD keeps pwm_speed constant indefinitely; the counter is held at 0.
- Reset mid-ramp: outputs return to reset values on that edge. No ramp-down is performed.

Optional Feature:
- Macro: PWM_RAMP_ABORT_EN.
- When defined, an extra input port stop_req (1 bit) exists:
  - stop_req=1 in RAMP_UP, RAMP_DOWN or HOLD forces target<=0 and state<=RAMP_DOWN on that edge.
  - The current dwell and counter are kept, so the ramp reverses mid-step without restarting the counter.
  - If pwm_speed is already 0, state goes to IDLE.
  - While stop_req=1, cmd_ready=0.
  - In IDLE, stop_req has no effect.
  - done pulses when 0 is reached.
- When undefined: no stop_req port; a ramp can only be redirected by a new command after reaching HOLD.

Test Plan:
- Reset, then IDLE, then accept speed=5, dwell=2 at edge E0:
  - pwm_enable=1 after E0.
  - pwm_speed=1,2,3,4,5 after E0+3, +6, +9, +12, +15.
  - busy=0 and done=1 for one cycle after E0+15; cmd_ready=1 in HOLD.
- From HOLD at 5, accept speed=2, dwell=0:
  - pwm_speed=4,3,2 on three consecutive edges.
  - done pulses once; pwm_enable stays 1.
- From HOLD at 2, accept speed=0, dwell=1:
  - pwm_speed=1 after 2 edges, then 0 after 4 edges.
  - pwm_enable falls on the same edge as pwm_speed reaches 0; state=IDLE; done pulses.
- During a RAMP_UP toward 7, drive cmd_valid with speed=1:
  - cmd_ready=0 and the command is ignored; ramp still reaches 7.
  - Then assert reset mid-ramp on a second run: next cycle pwm_speed=0, pwm_enable=0, busy=0.
- Accept speed equal to the current value (IDLE, speed=0):
  - No state change; pwm_enable stays 0; done=1 for exactly one cycle.
- With PWM_RAMP_ABORT_EN defined: ramp toward 6 with dwell=3; assert stop_req while pwm_speed=3:
  - Ramp reverses to 2,1,0 at 4-edge spacing.
  - IDLE is reached and done pulses; cmd_ready=0 while stop_req is held.
